psu_cntseq: RTL and testbench

- Sequencer for the PSU counter shift-register memory (psu_cntsrmem).
- On a start request it selects one schedule (INIT, MEAS or RESM) and plays it for N rounds:
  - waits each entry's `timing` cycles;
  - emits a codeword-valid pulse per entry;
  - advances the memory with next_id.
- Abort is safe: the memory is flushed back to entry 0, so the next schedule always starts aligned.

---
 rtl/psu_cntseq_pkg.sv | 37 +++
 rtl/psu_cntseq_timer.sv | 34 +++
 rtl/psu_cntseq.sv | 141 ++++++++++++++
 tb/tb_psu_cntseq.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psu_cntseq_pkg.sv
// Shared definitions for the PSU counter sequencer.
// Holds schedule selects, bus widths, FSM state encodings and a select-legality helper.
package psu_cntseq_pkg;

    localparam int unsigned TIME_BW  = 4;
    localparam int unsigned CWD_BW   = 8;
    localparam int unsigned IDLEN_BW = 4;
    localparam int unsigned RND_BW   = 8;

    // Schedule selects understood by psu_cntsrmem; 2'd3 is unused/illegal.
    localparam logic [1:0] SELCNT_INIT = 2'd0;
    localparam logic [1:0] SELCNT_MEAS = 2'd1;
    localparam logic [1:0] SELCNT_RESM = 2'd2;

    // Schedule lengths programmed into psu_cntsrmem.
    localparam int unsigned CNTLEN_INIT = 3;
    localparam int unsigned CNTLEN_MEAS = 2;
    localparam int unsigned CNTLEN_RESM = 3;

    localparam logic [1:0] PSU_CNTSEQ_ST_IDLE  = 2'd0;
    localparam logic [1:0] PSU_CNTSEQ_ST_RUN   = 2'd1;
    localparam logic [1:0] PSU_CNTSEQ_ST_FLUSH = 2'd2;
    localparam logic [1:0] PSU_CNTSEQ_ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = PSU_CNTSEQ_ST_IDLE,
        ST_RUN   = PSU_CNTSEQ_ST_RUN,
        ST_FLUSH = PSU_CNTSEQ_ST_FLUSH,
        ST_DONE  = PSU_CNTSEQ_ST_DONE
    } state_t;

    // True for selects that map to a programmed schedule.
    function automatic logic sel_legal(input logic [1:0] sel);
        return (sel == SELCNT_INIT) || (sel == SELCNT_MEAS) || (sel == SELCNT_RESM);
    endfunction

endpackage

// File: rtl/psu_cntseq_timer.sv
// Entry timer: counts cycles within one schedule entry and flags its last cycle.
// Ports: clk, rst (sync active-low), clr (force count to 0), en (count),
//        timing (entry duration, 0 treated as 1), cyc (current count), last_c (last cycle of entry).
module psu_cntseq_timer
    import psu_cntseq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [TIME_BW-1:0] timing,
    output logic [TIME_BW-1:0] cyc,
    output logic               last_c
);

    logic [TIME_BW-1:0] dur;

    // A zero-length entry still occupies one cycle.
    always_comb begin
        dur    = (timing == '0) ? TIME_BW'(1) : timing;
        last_c = en && (cyc == dur - TIME_BW'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc <= '0;
        end else if (clr) begin
            cyc <= '0;
        end else if (en) begin
            cyc <= last_c ? '0 : cyc + TIME_BW'(1);
        end
    end

endmodule

// File: rtl/psu_cntseq.sv
// PSU counter sequencer: plays an INIT/MEAS/RESM schedule from psu_cntsrmem for N rounds,
// pulsing cwd_valid per entry and next_id at each entry end; abort flushes the memory head
// back to entry 0.
// Ports: clk, rst (sync active-low); start/sel_req/n_round/abort request side;
//        sel_cwdNtime/next_id drive cntsrmem, timing/cwd/cwdsp/id_len come back from it;
//        busy, cwd_valid, cwd_out, cwdsp_out, done, err status/outputs.
module psu_cntseq
    import psu_cntseq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          sel_req,
    input  logic [RND_BW-1:0]   n_round,
    input  logic                abort,
    output logic [1:0]          sel_cwdNtime,
    output logic                next_id,
    input  logic [TIME_BW-1:0]  timing,
    input  logic [CWD_BW-1:0]   cwd,
    input  logic [CWD_BW-1:0]   cwdsp,
    input  logic [IDLEN_BW-1:0] id_len,
    output logic                busy,
    output logic                cwd_valid,
    output logic [CWD_BW-1:0]   cwd_out,
    output logic [CWD_BW-1:0]   cwdsp_out,
    output logic                done,
    output logic                err
);

    state_t              state;
    logic [IDLEN_BW-1:0] step;
    logic [RND_BW-1:0]   rnd;
    logic [1:0]          sel_q;
    logic [CWD_BW-1:0]   cwd_q;
    logic [CWD_BW-1:0]   cwdsp_q;
    logic                err_q;

    logic [TIME_BW-1:0]  cyc;
    logic                entry_end;
    logic                run;
    logic                at_head;
    logic                step_last;
    logic                abort_direct;
    logic [IDLEN_BW-1:0] step_nxt;

    psu_cntseq_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (!run || abort),
        .en     (run),
        .timing (timing),
        .cyc    (cyc),
        .last_c (entry_end)
    );

    // Decode of the registered FSM state; the bypass makes the codeword visible with its pulse.
    always_comb begin
        run          = (state == ST_RUN);
        at_head      = (step == '0) && (cyc == '0);
        step_last    = (step == id_len - IDLEN_BW'(1));
        step_nxt     = step_last ? '0 : step + IDLEN_BW'(1);
        // Aborting before any advance leaves the head aligned, so no next_id may fire.
        abort_direct = run && abort && at_head;
        next_id      = (run && entry_end && !abort_direct) || (state == ST_FLUSH);
        cwd_valid    = run && (cyc == '0);
        cwd_out      = cwd_valid ? cwd : cwd_q;
        cwdsp_out    = cwd_valid ? cwdsp : cwdsp_q;
        busy         = (state != ST_IDLE);
        done         = (state == ST_DONE);
        err          = err_q;
        sel_cwdNtime = sel_q;
    end

    // Sequencer FSM with its step/round bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            step    <= '0;
            rnd     <= '0;
            sel_q   <= SELCNT_INIT;
            cwd_q   <= '0;
            cwdsp_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (cwd_valid) begin
                cwd_q   <= cwd;
                cwdsp_q <= cwdsp;
            end
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if (sel_legal(sel_req)) begin
                            sel_q <= sel_req;
                            rnd   <= (n_round == '0) ? '0 : n_round - RND_BW'(1);
                            step  <= '0;
                            state <= ST_RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        if (at_head) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_FLUSH;
                            if (entry_end) begin
                                step <= step_nxt;
                            end
                        end
                    end else if (entry_end) begin
                        step <= step_nxt;
                        if (step_last) begin
                            if (rnd == '0) begin
                                state <= ST_DONE;
                            end else begin
                                rnd <= rnd - RND_BW'(1);
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    // Keep advancing the memory until the head wraps back to entry 0.
                    step <= step_nxt;
                    if (step_nxt == '0) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psu_cntseq.sv
// Testbench for psu_cntseq with a behavioural psu_cntsrmem model and an expectation scoreboard.
module tb_psu_cntseq;
    import psu_cntseq_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [1:0]          sel_req;
    logic [RND_BW-1:0]   n_round;
    logic                abort;
    logic [1:0]          sel_cwdNtime;
    logic                next_id;
    logic [TIME_BW-1:0]  timing;
    logic [CWD_BW-1:0]   cwd;
    logic [CWD_BW-1:0]   cwdsp;
    logic [IDLEN_BW-1:0] id_len;
    logic                busy;
    logic                cwd_valid;
    logic [CWD_BW-1:0]   cwd_out;
    logic [CWD_BW-1:0]   cwdsp_out;
    logic                done;
    logic                err;

    psu_cntseq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sel_req      (sel_req),
        .n_round      (n_round),
        .abort        (abort),
        .sel_cwdNtime (sel_cwdNtime),
        .next_id      (next_id),
        .timing       (timing),
        .cwd          (cwd),
        .cwdsp        (cwdsp),
        .id_len       (id_len),
        .busy         (busy),
        .cwd_valid    (cwd_valid),
        .cwd_out      (cwd_out),
        .cwdsp_out    (cwdsp_out),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Memory contents: INIT {3,1,2}, MEAS {2,1}, RESM {1,0,1}.
    int tim_tbl   [3][3] = '{'{3, 1, 2}, '{2, 1, 0}, '{1, 0, 1}};
    int cwd_tbl   [3][3] = '{'{'h11, 'h12, 'h13}, '{'h21, 'h22, 0}, '{'h31, 'h32, 'h33}};
    int cwdsp_tbl [3][3] = '{'{'hA1, 'hA2, 'hA3}, '{'hB1, 'hB2, 0}, '{'hC1, 'hC2, 'hC3}};
    int len_tbl   [3]    = '{3, 2, 3};
    int head      [3]    = '{0, 0, 0};

    always_comb begin
        int s;
        s      = int'(sel_cwdNtime);
        timing = '0;
        cwd    = '0;
        cwdsp  = '0;
        id_len = '0;
        if (s < 3) begin
            timing = TIME_BW'(tim_tbl[s][head[s]]);
            cwd    = CWD_BW'(cwd_tbl[s][head[s]]);
            cwdsp  = CWD_BW'(cwdsp_tbl[s][head[s]]);
            id_len = IDLEN_BW'(len_tbl[s]);
        end
    end

    always @(posedge clk) begin
        int s;
        s = int'(sel_cwdNtime);
        if (!rst) begin
            for (int i = 0; i < 3; i++) head[i] <= 0;
        end else if (next_id && s < 3) begin
            head[s] <= (head[s] + 1 >= len_tbl[s]) ? 0 : head[s] + 1;
        end
    end

    typedef struct {
        int          rel;
        logic [7:0]  c;
        logic [7:0]  s;
    } cw_t;

    cw_t exp_cw [$];
    int  exp_nid [$];
    int  exp_done_rel;
    int  cyc_cnt = 0;
    int  start_cyc = 0;
    int  done_cnt = 0;
    int  last_done_rel = -1;
    int  n_pass = 0;
    int  n_fail = 0;
    int  n_total = 0;
    bit  mon_en = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop an expectation for every codeword pulse and advance pulse.
    always @(negedge clk) begin
        int  rel;
        cw_t x;
        int  r;
        rel = cyc_cnt - start_cyc;
        if (mon_en) begin
            if (cwd_valid) begin
                chk("cwd_valid_expected", 32'(exp_cw.size() != 0), 32'd1);
                if (exp_cw.size() != 0) begin
                    x = exp_cw.pop_front();
                    chk("cwd_valid_cycle", 32'(rel), 32'(x.rel));
                    chk("cwd_out", 32'(cwd_out), 32'(x.c));
                    chk("cwdsp_out", 32'(cwdsp_out), 32'(x.s));
                end
            end
            if (next_id) begin
                chk("next_id_expected", 32'(exp_nid.size() != 0), 32'd1);
                if (exp_nid.size() != 0) begin
                    r = exp_nid.pop_front();
                    chk("next_id_cycle", 32'(rel), 32'(r));
                end
            end
            if (done) begin
                done_cnt++;
                last_done_rel = rel;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_sched(input int s, input int rounds);
        int  off;
        int  d;
        cw_t x;
        off = 1;
        for (int r = 0; r < ((rounds < 1) ? 1 : rounds); r++) begin
            for (int e = 0; e < len_tbl[s]; e++) begin
                d     = (tim_tbl[s][e] == 0) ? 1 : tim_tbl[s][e];
                x.rel = off;
                x.c   = 8'(cwd_tbl[s][e]);
                x.s   = 8'(cwdsp_tbl[s][e]);
                exp_cw.push_back(x);
                exp_nid.push_back(off + d - 1);
                off += d;
            end
        end
        exp_done_rel = off;
    endtask

    task automatic push_cw(input int rel, input int c, input int s);
        cw_t x;
        x.rel = rel;
        x.c   = 8'(c);
        x.s   = 8'(s);
        exp_cw.push_back(x);
    endtask

    task automatic do_start(input logic [1:0] sel, input int nr);
        start     = 1'b1;
        sel_req   = sel;
        n_round   = RND_BW'(nr);
        start_cyc = cyc_cnt;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < maxc) begin
            tick(1);
            n++;
        end
        chk("done_seen", 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_cw_left"}, 32'(exp_cw.size()), 32'd0);
        chk({tag, "_nid_left"}, 32'(exp_nid.size()), 32'd0);
        exp_cw.delete();
        exp_nid.delete();
    endtask

    initial begin
        int d0;
        rst     = 1'b0;
        start   = 1'b0;
        sel_req = 2'd0;
        n_round = '0;
        abort   = 1'b0;
        tick(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cwd_valid", 32'(cwd_valid), 32'd0);
        chk("rst_next_id", 32'(next_id), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cwd_out", 32'(cwd_out), 32'd0);
        chk("rst_sel", 32'(sel_cwdNtime), 32'(SELCNT_INIT));
        rst    = 1'b1;
        mon_en = 1'b1;
        tick(2);

        // INIT, one round: pulses at 1,4,5; next_id at 3,4,6; done at 7.
        push_sched(0, 1);
        do_start(SELCNT_INIT, 1);
        chk("init_busy", 32'(busy), 32'd1);
        wait_done(40);
        chk("init_done_rel", 32'(last_done_rel), 32'(exp_done_rel));
        chk("init_idle_busy", 32'(busy), 32'd0);
        chk_drained("init");
        tick(2);

        // MEAS, three rounds; memory head must end on entry 0.
        push_sched(1, 3);
        do_start(SELCNT_MEAS, 3);
        wait_done(60);
        chk("meas_done_rel", 32'(last_done_rel), 32'(exp_done_rel));
        chk("meas_head", 32'(head[1]), 32'd0);
        chk("meas_sel_hold", 32'(sel_cwdNtime), 32'(SELCNT_MEAS));
        chk_drained("meas");
        tick(2);

        // RESM with a zero-timing entry and n_round=0 (played once).
        push_sched(2, 0);
        d0 = done_cnt;
        do_start(SELCNT_RESM, 0);
        wait_done(40);
        chk("resm_done_rel", 32'(last_done_rel), 32'(exp_done_rel));
        tick(3);
        chk("resm_done_count", 32'(done_cnt - d0), 32'd1);
        chk_drained("resm");

        // INIT abort at step 1, cyc 0: next_id at abort cycle and one FLUSH cycle.
        push_cw(1, 'h11, 'hA1);
        push_cw(4, 'h12, 'hA2);
        exp_nid.push_back(3);
        exp_nid.push_back(4);
        exp_nid.push_back(5);
        d0 = done_cnt;
        do_start(SELCNT_INIT, 1);
        tick(3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("flush_busy", 32'(busy), 32'd1);
        tick(1);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_head", 32'(head[0]), 32'd0);
        tick(3);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk_drained("abort");

        // The following INIT start is aligned at entry 0.
        push_sched(0, 1);
        do_start(SELCNT_INIT, 1);
        wait_done(40);
        chk("realign_done_rel", 32'(last_done_rel), 32'(exp_done_rel));
        chk_drained("realign");
        tick(2);

        // Illegal select: err pulse, never busy.
        do_start(2'd3, 1);
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_busy", 32'(busy), 32'd0);
        tick(1);
        chk("illegal_err_clear", 32'(err), 32'd0);
        chk("illegal_busy2", 32'(busy), 32'd0);
        chk_drained("illegal");

        // Abort and start together in IDLE: nothing starts.
        abort = 1'b1;
        do_start(SELCNT_INIT, 1);
        abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);
        chk("abort_start_err", 32'(err), 32'd0);
        tick(2);
        chk("abort_start_busy2", 32'(busy), 32'd0);
        chk_drained("abort_start");

        // Reset mid-RUN of MEAS.
        push_cw(1, 'h21, 'hB1);
        exp_nid.push_back(2);
        push_cw(3, 'h22, 'hB2);
        exp_nid.push_back(3);
        do_start(SELCNT_MEAS, 2);
        tick(2);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_cwd_out", 32'(cwd_out), 32'd0);
        chk("mrst_cwdsp_out", 32'(cwdsp_out), 32'd0);
        chk("mrst_sel", 32'(sel_cwdNtime), 32'(SELCNT_INIT));
        chk("mrst_next_id", 32'(next_id), 32'd0);
        chk("mrst_cwd_valid", 32'(cwd_valid), 32'd0);
        chk_drained("mrst");
        tick(2);

        // Start asserted only during DONE is ignored.
        push_sched(0, 1);
        do_start(SELCNT_INIT, 1);
        tick(6);
        start   = 1'b1;
        sel_req = SELCNT_MEAS;
        tick(1);
        start = 1'b0;
        chk("done_start_rel", 32'(last_done_rel), 32'd7);
        chk("done_start_busy", 32'(busy), 32'd0);
        tick(1);
        chk("done_start_busy2", 32'(busy), 32'd0);
        chk("done_start_sel", 32'(sel_cwdNtime), 32'(SELCNT_INIT));
        chk_drained("done_start");
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
